// File: rtl/alarm_time_keeper.sv
// Alarm setting registers plus IDLE/ARMED/RINGING alarm controller.
// Rings on a rising edge of the time/alarm match; silenced by dismiss, timeout or disarm.
module alarm_time_keeper #(
    parameter int unsigned RING_SECS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upsec,
    input  logic       upmin,
    input  logic       uphour,
    input  logic       arm_en,
    input  logic       dismiss,
    input  logic       sec_tick,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic [5:0] alarm_sec,
    output logic [5:0] alarm_min,
    output logic [4:0] alarm_hour,
    output logic       ringing,
    output logic [1:0] alarm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(RING_SECS - 1);

    state_t     state;
    logic [7:0] ring_cnt;
    logic       match;
    logic       match_q;

    assign match = (cur_sec == alarm_sec) && (cur_min == alarm_min) && (cur_hour == alarm_hour);

    // match_q resets high so a 00:00:00 current time cannot fire straight out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_sec   <= '0;
            alarm_min   <= '0;
            alarm_hour  <= '0;
            state       <= IDLE;
            ringing     <= 1'b0;
            alarm_state <= 2'd0;
            ring_cnt    <= '0;
            match_q     <= 1'b1;
        end else begin
            match_q <= match;

            if (state != RINGING) begin
                if (upsec)
                    alarm_sec <= (alarm_sec == 6'd59) ? '0 : alarm_sec + 6'd1;
                if (upmin)
                    alarm_min <= (alarm_min == 6'd59) ? '0 : alarm_min + 6'd1;
                if (uphour)
                    alarm_hour <= (alarm_hour == 5'd23) ? '0 : alarm_hour + 5'd1;
            end

            case (state)
                IDLE: begin
                    if (arm_en) begin
                        state       <= ARMED;
                        alarm_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!arm_en) begin
                        state       <= IDLE;
                        alarm_state <= IDLE;
                    end else if (match && !match_q) begin
                        state       <= RINGING;
                        alarm_state <= RINGING;
                        ringing     <= 1'b1;
                        ring_cnt    <= '0;
                    end
                end
                RINGING: begin
                    if (sec_tick)
                        ring_cnt <= ring_cnt + 8'd1;
                    if (!arm_en) begin
                        state       <= IDLE;
                        alarm_state <= IDLE;
                        ringing     <= 1'b0;
                    end else if (dismiss || (sec_tick && ring_cnt == LAST_CNT)) begin
                        state       <= ARMED;
                        alarm_state <= ARMED;
                        ringing     <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    alarm_state <= IDLE;
                    ringing     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper: behavioural model compared every cycle,
// plus hand-computed literal checks at key points.
module tb_alarm_time_keeper;

    localparam int RS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       upsec = 0, upmin = 0, uphour = 0, arm_en = 0, dismiss = 0, sec_tick = 0;
    logic [5:0] cur_sec = 0, cur_min = 0;
    logic [4:0] cur_hour = 0;
    logic [5:0] alarm_sec, alarm_min;
    logic [4:0] alarm_hour;
    logic       ringing;
    logic [1:0] alarm_state;

    int total = 0;
    int bad = 0;

    alarm_time_keeper #(.RING_SECS(RS)) dut (
        .clk(clk), .reset(reset), .upsec(upsec), .upmin(upmin), .uphour(uphour),
        .arm_en(arm_en), .dismiss(dismiss), .sec_tick(sec_tick),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
        .ringing(ringing), .alarm_state(alarm_state)
    );

    always #5 clk = ~clk;

    // Model: alarm time as integers, mode 0 off / 1 armed / 2 ringing, ticks heard while ringing
    int m_sec, m_min, m_hour, m_mode, m_ticks;
    bit m_prev_hit;
    logic m_hit;
    assign m_hit = (int'(cur_sec) == m_sec) && (int'(cur_min) == m_min) && (int'(cur_hour) == m_hour);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sec <= 0; m_min <= 0; m_hour <= 0;
            m_mode <= 0; m_ticks <= 0; m_prev_hit <= 1'b1;
        end else begin
            m_prev_hit <= m_hit;
            if (m_mode != 2) begin
                m_sec  <= (m_sec  + (upsec  ? 1 : 0)) % 60;
                m_min  <= (m_min  + (upmin  ? 1 : 0)) % 60;
                m_hour <= (m_hour + (uphour ? 1 : 0)) % 24;
            end
            if (!arm_en)
                m_mode <= 0;
            else if (m_mode == 0)
                m_mode <= 1;
            else if (m_mode == 1) begin
                if (m_hit && !m_prev_hit) begin
                    m_mode  <= 2;
                    m_ticks <= 0;
                end
            end else begin
                if (sec_tick) m_ticks <= m_ticks + 1;
                if (dismiss || (sec_tick && m_ticks + 1 >= RS)) m_mode <= 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_sec",   int'(alarm_sec),   m_sec);
        chk("cmp_min",   int'(alarm_min),   m_min);
        chk("cmp_hour",  int'(alarm_hour),  m_hour);
        chk("cmp_state", int'(alarm_state), m_mode);
        chk("cmp_ring",  int'(ringing),     (m_mode == 2) ? 1 : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    initial begin
        #12;
        chk("rst_state", int'(alarm_state), 0);
        chk("rst_ring",  int'(ringing), 0);
        chk("rst_sec",   int'(alarm_sec), 0);
        reset = 0;
        step();

        // Seconds and hours wrap, minutes untouched
        upsec = 1;
        repeat (59) step();
        chk("sec_59", int'(alarm_sec), 59);
        step();
        upsec = 0;
        chk("sec_wrap", int'(alarm_sec), 0);
        uphour = 1;
        repeat (24) step();
        uphour = 0;
        chk("hour_wrap", int'(alarm_hour), 0);
        chk("min_hold", int'(alarm_min), 0);

        // Set 07:30:00 using simultaneous edits
        uphour = 1; upmin = 1;
        repeat (7) step();
        uphour = 0;
        repeat (23) step();
        upmin = 0;
        chk("set_hour", int'(alarm_hour), 7);
        chk("set_min",  int'(alarm_min), 30);

        // Trigger on rising match
        set_cur(7, 29, 59);
        arm_en = 1;
        step();
        chk("armed", int'(alarm_state), 1);
        step();
        set_cur(7, 30, 0);
        step();
        chk("trig_state", int'(alarm_state), 2);
        chk("trig_ring",  int'(ringing), 1);

        // Edit ignored while ringing, then dismiss; held match must not retrigger
        upsec = 1; step(); upsec = 0;
        chk("edit_ignored", int'(alarm_sec), 0);
        dismiss = 1; step(); dismiss = 0;
        chk("dismiss_state", int'(alarm_state), 1);
        chk("dismiss_ring",  int'(ringing), 0);
        repeat (3) step();
        chk("no_retrig", int'(alarm_state), 1);
        dismiss = 1; step(); dismiss = 0;
        chk("dismiss_armed_noop", int'(alarm_state), 1);

        // Timeout after RS ticks
        set_cur(7, 29, 59); step();
        set_cur(7, 30, 0);  step();
        chk("retrig", int'(alarm_state), 2);
        sec_tick = 1; step(); sec_tick = 0; step();
        sec_tick = 1; step(); sec_tick = 0;
        chk("tick2_ring", int'(alarm_state), 2);
        step();
        sec_tick = 1; step(); sec_tick = 0;
        chk("timeout", int'(alarm_state), 1);
        repeat (3) step();
        chk("timeout_no_retrig", int'(alarm_state), 1);

        // Disarm beats dismiss
        set_cur(7, 29, 59); step();
        set_cur(7, 30, 0);  step();
        chk("retrig2", int'(alarm_state), 2);
        arm_en = 0; dismiss = 1; step(); dismiss = 0;
        chk("disarm_prio", int'(alarm_state), 0);

        // Move alarm to 12:34:56 and ring, then async reset
        for (int i = 0; i < 56; i++) begin
            upsec = 1; uphour = (i < 5); upmin = (i < 4);
            step();
        end
        upsec = 0; uphour = 0; upmin = 0;
        chk("set2_hour", int'(alarm_hour), 12);
        chk("set2_min",  int'(alarm_min), 34);
        chk("set2_sec",  int'(alarm_sec), 56);
        set_cur(12, 34, 55); arm_en = 1;
        step(); step();
        set_cur(12, 34, 56); step();
        chk("ring3", int'(ringing), 1);
        #2 reset = 1;
        #1;
        chk("async_state", int'(alarm_state), 0);
        chk("async_ring",  int'(ringing), 0);
        chk("async_hour",  int'(alarm_hour), 0);
        chk("async_min",   int'(alarm_min), 0);
        chk("async_sec",   int'(alarm_sec), 0);
        set_cur(0, 0, 0);
        #3 reset = 0;
        repeat (4) step();
        chk("post_rst_armed", int'(alarm_state), 1);
        chk("post_rst_ring",  int'(ringing), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
